// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: operand/product widths and the result FIFO entry
// shared by mul_arbiter and its result FIFO.
package mul_arb_pkg;

    localparam int OPW     = 64;
    localparam int PRODW   = 128;
    localparam int IDW_MAX = 3;

    typedef struct packed {
        logic [IDW_MAX-1:0] id;
        logic [PRODW-1:0]   p;
    } res_t;

    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off >= n) ? base + off - n : base + off;
    endfunction

endpackage

// File: rtl/mul_arb_fifo.sv
// mul_arb_fifo: synchronous first-word-fall-through FIFO; reads of an
// empty FIFO return zero, and a write is taken when full if a pop coincides.
module mul_arb_fifo
    import mul_arb_pkg::*;
#(
    parameter  int W     = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_data,
    output logic [AW:0]  o_count,
    output logic         o_full,
    output logic         o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_wr;
    logic          w_rd;

    assign o_count   = r_cnt;
    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign w_rd      = i_rd_en && !o_empty;
    assign w_wr      = i_wr_en && (!o_full || w_rd);
    assign o_rd_data = o_empty ? '0 : r_mem[r_rp];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wp] <= i_wr_data;
    end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one fixed-latency multiplier among NREQ requesters.
// Define MUL_ARB_RR_EN for round-robin; otherwise lowest index wins.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter  int NREQ       = 4,
    parameter  int MUL_LAT    = 8,
    parameter  int FIFO_DEPTH = 8,
    localparam int IDW        = $clog2(NREQ),
    localparam int OCW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ*OPW-1:0]  i_req_a,
    input  logic [NREQ*OPW-1:0]  i_req_b,
    output logic                 o_resp_valid,
    input  logic                 i_resp_ready,
    output logic [IDW-1:0]       o_resp_id,
    output logic [PRODW-1:0]     o_resp_p,
    output logic [OPW-1:0]       o_mul_a,
    output logic [OPW-1:0]       o_mul_b,
    input  logic [PRODW-1:0]     i_mul_p,
    output logic                 o_busy
);

    logic [OPW-1:0]     w_a [NREQ];
    logic [OPW-1:0]     w_b [NREQ];
    logic [OCW-1:0]     r_occ;
    logic [MUL_LAT-1:0] r_tag_vld;
    logic [IDW-1:0]     r_tag_id [MUL_LAT];
    logic [IDW-1:0]     w_base;
    logic [IDW-1:0]     w_idx;
    logic [IDW-1:0]     w_gnt_id;
    logic               w_gnt_vld;
    logic               w_arb_en;
    logic               w_acc;
    logic               w_pop;
    logic               w_cap;
    res_t               w_wr_ent;
    res_t               w_head;
    logic [OCW-1:0]     w_fifo_cnt;
    logic               w_fifo_full;
    logic               w_fifo_empty;

    for (genvar g = 0; g < NREQ; g++) begin : g_ops
        assign w_a[g] = i_req_a[g*OPW +: OPW];
        assign w_b[g] = i_req_b[g*OPW +: OPW];
    end

`ifdef MUL_ARB_RR_EN
    logic [IDW-1:0] r_ptr;

    always_ff @(posedge i_clk) begin
        if (i_rst)      r_ptr <= '0;
        else if (w_acc) r_ptr <= IDW'(wrap_idx(int'(w_gnt_id), 1, NREQ));
    end

    assign w_base = r_ptr;
`else
    assign w_base = '0;
`endif

    // Scan from lowest priority up so the highest-priority hit is kept.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        w_idx     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = IDW'(wrap_idx(int'(w_base), k, NREQ));
            if (i_req_valid[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = w_idx;
            end
        end
    end

    assign w_arb_en    = !i_rst && (r_occ < OCW'(FIFO_DEPTH));
    assign w_acc       = w_arb_en && w_gnt_vld;
    assign o_req_ready = w_acc ? (NREQ'(1) << w_gnt_id) : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tag_vld <= '0;
            o_mul_a   <= '0;
            o_mul_b   <= '0;
        end else begin
            r_tag_vld <= {r_tag_vld[MUL_LAT-2:0], w_acc};
            if (w_acc) begin
                o_mul_a <= w_a[w_gnt_id];
                o_mul_b <= w_b[w_gnt_id];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        r_tag_id[0] <= w_gnt_id;
        for (int s = 1; s < MUL_LAT; s++) r_tag_id[s] <= r_tag_id[s-1];
    end

    assign w_cap       = r_tag_vld[MUL_LAT-1];
    assign w_wr_ent.id = IDW_MAX'(r_tag_id[MUL_LAT-1]);
    assign w_wr_ent.p  = i_mul_p;

    mul_arb_fifo #(
        .W     ($bits(res_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_cap),
        .i_wr_data (w_wr_ent),
        .i_rd_en   (i_resp_ready),
        .o_rd_data (w_head),
        .o_count   (w_fifo_cnt),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    assign o_resp_valid = !w_fifo_empty;
    assign o_resp_id    = IDW'(w_head.id);
    assign o_resp_p     = w_head.p;
    assign w_pop        = o_resp_valid && i_resp_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_occ <= '0;
        end else begin
            case ({w_acc, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_busy = (r_occ != '0);

    // occ covers in-flight work plus stored results, so these always hold.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(w_cap && w_fifo_full && !w_pop));
    a_cnt_le_occ: assert property (@(posedge i_clk) disable iff (i_rst)
        w_fifo_cnt <= r_occ);

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: scoreboard bench for mul_arbiter, with a behavioural
// fixed-latency multiplier on the mul_a/mul_b/mul_p side.
module tb_mul_arbiter;
    import mul_arb_pkg::*;

    localparam int NREQ       = 4;
    localparam int MUL_LAT    = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int IDW        = 2;
    localparam int NV         = 9;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [PRODW-1:0] p;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*OPW-1:0] req_a;
    logic [NREQ*OPW-1:0] req_b;
    logic                resp_valid;
    logic                resp_ready;
    logic [IDW-1:0]      resp_id;
    logic [PRODW-1:0]    resp_p;
    logic [OPW-1:0]      mul_a;
    logic [OPW-1:0]      mul_b;
    logic [PRODW-1:0]    mul_p;
    logic                busy;

    logic       tf_wr;
    logic       tf_rd;
    logic [7:0] tf_wd;
    logic [7:0] tf_rdata;
    logic [3:0] tf_cnt;
    logic       tf_full;
    logic       tf_empty;

    always #5 clk = ~clk;

    mul_arbiter #(
        .NREQ       (NREQ),
        .MUL_LAT    (MUL_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_id    (resp_id),
        .o_resp_p     (resp_p),
        .o_mul_a      (mul_a),
        .o_mul_b      (mul_b),
        .i_mul_p      (mul_p),
        .o_busy       (busy)
    );

    mul_arb_fifo #(
        .W     (8),
        .DEPTH (8)
    ) u_tf (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr_en   (tf_wr),
        .i_wr_data (tf_wd),
        .i_rd_en   (tf_rd),
        .o_rd_data (tf_rdata),
        .o_count   (tf_cnt),
        .o_full    (tf_full),
        .o_empty   (tf_empty)
    );

    // Operands updated at edge E give a product sampled at edge E+MUL_LAT.
    logic [PRODW-1:0] mpipe [MUL_LAT-1];
    always @(posedge clk) begin
        mpipe[0] <= {64'b0, mul_a} * {64'b0, mul_b};
        for (int s = 1; s < MUL_LAT - 1; s++) mpipe[s] <= mpipe[s-1];
    end
    assign mul_p = mpipe[MUL_LAT-2];

    logic [OPW-1:0] va [NV] = '{
        64'd3, 64'hFFFFFFFFFFFFFFFF, 64'h100000000, 64'h8000000000000000,
        64'hFFFFFFFFFFFFFFFF, 64'h123456789, 64'hDEADBEEF, 64'd7,
        64'h00FFFFFFFABCFFF};
    logic [OPW-1:0] vb [NV] = '{
        64'd5, 64'd2, 64'h100000000, 64'h8000000000000000,
        64'hFFFFFFFFFFFFFFFF, 64'h10, 64'h100000000, 64'hFFFFFFFFFFFFFFFF,
        64'hABCF};
    logic [PRODW-1:0] vp [NV] = '{
        128'd15,
        128'h1FFFFFFFFFFFFFFFE,
        128'h10000000000000000,
        128'h40000000000000000000000000000000,
        128'hFFFFFFFFFFFFFFFE0000000000000001,
        128'h1234567890,
        128'hDEADBEEF00000000,
        128'h6FFFFFFFFFFFFFFF9,
        128'(64'h00FFFFFFFABCFFF) * 128'(64'hABCF)};

    exp_t sb [$];
    int   gq [$];
    logic [7:0] tq [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_acc   = 0;
    int   rem [NREQ];
    int   vix [NREQ];
    exp_t mon_e;

    task automatic chk(input string nm, input logic [PRODW-1:0] act,
                       input logic [PRODW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", 128'(resp_id), 128'hDEAD);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_id", 128'(resp_id), 128'(mon_e.id));
                chk("resp_p", resp_p, mon_e.p);
            end
        end
    end

    task automatic load(input int i);
        req_a[i*OPW +: OPW] = va[vix[i]];
        req_b[i*OPW +: OPW] = vb[vix[i]];
    endtask

    task automatic start(input int i, input int n, input int first);
        rem[i] = n;
        vix[i] = first;
        load(i);
        req_valid[i] = 1'b1;
    endtask

    task automatic step();
        logic [NREQ-1:0] acc;
        @(negedge clk);
        acc = rst ? '0 : (req_valid & req_ready);
        chk("ready_onehot0", 128'($onehot0(req_ready)), 128'd1);
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                n_acc++;
                sb.push_back(exp_t'{id: IDW'(i), p: vp[vix[i]]});
                if (gq.size() > 0) chk("grant_id", 128'(i), 128'(gq.pop_front()));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                rem[i]--;
                vix[i] = (vix[i] + 1) % NV;
                if (rem[i] == 0) req_valid[i] = 1'b0;
                else load(i);
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        resp_ready = 1'b1;
        while ((sb.size() != 0 || busy || req_valid != '0) && t < 400) begin
            step();
            t++;
        end
        chk("drain_in_time", 128'(t < 400), 128'd1);
        chk("sb_empty", 128'(sb.size()), 128'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        gq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0;
        int t;
        logic any_v;
        rst = 1'b1;
        resp_ready = 1'b0;
        tf_wr = 1'b0;
        tf_rd = 1'b0;
        tf_wd = '0;
        for (int i = 0; i < NREQ; i++) begin
            vix[i] = i;
            rem[i] = 0;
            load(i);
        end
        req_valid = '1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("rst_req_ready", 128'(req_ready), 128'd0);
        chk("rst_resp_valid", 128'(resp_valid), 128'd0);
        chk("rst_resp_id", 128'(resp_id), 128'd0);
        chk("rst_resp_p", resp_p, 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_mul_a", 128'(mul_a), 128'd0);
        chk("rst_mul_b", 128'(mul_b), 128'd0);
        req_valid = '0;
        rst = 1'b0;

        // FIFO: simultaneous write and pop while full
        for (int k = 0; k < 8; k++) begin
            tf_wr = 1'b1;
            tf_wd = 8'(k + 1);
            tq.push_back(8'(k + 1));
            @(posedge clk);
            #1;
        end
        tf_wr = 1'b0;
        chk("tf_count_full", 128'(tf_cnt), 128'd8);
        chk("tf_full", 128'(tf_full), 128'd1);
        for (int k = 0; k < 2; k++) begin
            tf_wr = 1'b1;
            tf_rd = 1'b1;
            tf_wd = 8'(9 + k);
            chk("tf_head_wr_rd", 128'(tf_rdata), 128'(tq.pop_front()));
            tq.push_back(8'(9 + k));
            @(posedge clk);
            #1;
            chk("tf_count_wr_rd", 128'(tf_cnt), 128'd8);
        end
        tf_wr = 1'b0;
        while (tq.size() > 0) begin
            chk("tf_order", 128'(tf_rdata), 128'(tq.pop_front()));
            @(posedge clk);
            #1;
        end
        tf_rd = 1'b0;
        chk("tf_empty", 128'(tf_empty), 128'd1);
        chk("tf_empty_data", 128'(tf_rdata), 128'd0);

        // Single request: latency and all-ones product
        do_reset();
        resp_ready = 1'b0;
        a0 = n_acc;
        start(2, 1, 4);
        t = 0;
        while (n_acc == a0 && t < 5) begin
            step();
            t++;
        end
        chk("t1_accepted", 128'(n_acc - a0), 128'd1);
        chk("t1_mul_a", 128'(mul_a), 128'(va[4]));
        for (int k = 1; k <= MUL_LAT; k++) begin
            step();
            if (k == MUL_LAT - 1) chk("t1_early_valid", 128'(resp_valid), 128'd0);
        end
        chk("t1_valid", 128'(resp_valid), 128'd1);
        chk("t1_id", 128'(resp_id), 128'd2);
        chk("t1_p", resp_p, 128'hFFFFFFFFFFFFFFFE0000000000000001);
        drain();

        // All four requesters valid
        do_reset();
        resp_ready = 1'b1;
`ifdef MUL_ARB_RR_EN
        gq = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
`else
        gq = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
`endif
        start(0, 4, 0);
        start(1, 3, 2);
        start(2, 3, 4);
        start(3, 3, 6);
        drain();
        chk("t2_grants_left", 128'(gq.size()), 128'd0);

        // Backpressure: exactly FIFO_DEPTH accepts, then one per pop
        do_reset();
        resp_ready = 1'b0;
        a0 = n_acc;
        start(1, 20, 1);
        repeat (30) step();
        chk("t3_accepts", 128'(n_acc - a0), 128'd8);
        chk("t3_ready_low", 128'(req_ready), 128'd0);
        chk("t3_busy", 128'(busy), 128'd1);
        chk("t3_fifo_count", 128'(dut.w_fifo_cnt), 128'd8);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        step();
        chk("t3_one_more", 128'(n_acc - a0), 128'd9);
        repeat (8) step();
        chk("t3_still_nine", 128'(n_acc - a0), 128'd9);
        drain();

        // Reset while operations are in flight
        do_reset();
        resp_ready = 1'b1;
        a0 = n_acc;
        start(0, 2, 8);
        t = 0;
        while (n_acc - a0 < 2 && t < 10) begin
            step();
            t++;
        end
        chk("t4_accepts", 128'(n_acc - a0), 128'd2);
        repeat (2) step();
        do_reset();
        any_v = 1'b0;
        repeat (14) begin
            step();
            if (resp_valid) any_v = 1'b1;
        end
        chk("t4_no_valid", 128'(any_v), 128'd0);
        chk("t4_busy", 128'(busy), 128'd0);
        chk("t4_occ", 128'(dut.r_occ), 128'd0);
        start(3, 1, 4);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Shares one pipelined 64x64 Karatsuba multiplier (`hw4_q3` style: operands in, 128-bit product out, fixed latency, no stall) among NREQ requesters. Arbitrates per cycle, issues at most one operand pair per clock, and tracks the requester ID of each operation alongside the multiplier pipeline. Returns each product, tagged with its ID, through a result FIFO with valid/ready backpressure. Sits between the requesting datapath blocks and the multiplier instance.

## Interface
- NREQ, 4: number of requesters (2..8).
- MUL_LAT, 8: clock edges from a `mul_a`/`mul_b` update to the edge where the matching `mul_p` is sampled.
- FIFO_DEPTH, 8: result FIFO entries; power of two, at least MUL_LAT.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*64  operand A; requester i in bits [64i+63:64i].
- req_b  in  NREQ*64  operand B; same packing.
- resp_valid  out  1  result FIFO head valid.
- resp_ready  in  1  consumer accepts head.
- resp_id  out  clog2(NREQ)  requester index of the head result.
- resp_p  out  128  head product, unsigned.
- mul_a, mul_b  out  64  registered operands to the multiplier.
- mul_p  in  128  multiplier product.
- busy  out  1  any operation in flight or any result pending.

## Operation
- Accept: `occ` counts in-flight operations plus FIFO entries. Arbitration is enabled only when `occ < FIFO_DEPTH`; when enabled, one `req_valid` requester is granted and `req_ready[i]` for that requester is 1 in the same cycle.
- `req_ready` may depend combinationally on `req_valid`. It never depends on `resp_ready`.
- A requester holds `req_valid`, `req_a` and `req_b` stable until accepted.
- Issue: on the accept edge, `mul_a`/`mul_b` load the granted operands. A tag shift register, MUL_LAT stages of {valid, id}, loads {1, grant id}. With no accept, the register loads {0, x} and `mul_a`/`mul_b` hold their values.
- Capture: when the last tag stage is valid, the edge writes {id, `mul_p`} into the FIFO. The FIFO never overflows because of the `occ` gating.
- Drain: the FIFO is first-word fall-through. `resp_valid` = not empty. A pop occurs when `resp_valid & resp_ready`.
- `occ` update: +1 on accept, −1 on pop, unchanged when both or neither occur.
- Products are full 128-bit unsigned with no truncation. Results return in issue order.
- Simultaneous FIFO write and pop in the same cycle are both performed, including when the FIFO is full, since a full FIFO implies nothing is in flight.
- `busy` = (`occ` != 0).
- Reset, including mid-operation: clears all tag valids, FIFO pointers, `occ`, and the arbiter pointer. `mul_a`/`mul_b` go to 0. In-flight products are discarded, and any `mul_p` garbage is ignored because tag valids are 0.
- Reset values: `req_ready` = 0 during reset, `resp_valid` = 0, `resp_id` = 0, `resp_p` = 0 (an empty FIFO drives zeros), `busy` = 0, `mul_a` = `mul_b` = 0.

## Timing
- Throughput: one accept per cycle while `occ < FIFO_DEPTH`.
- Latency: for an accept at edge E, `resp_valid` rises in the cycle after edge E+MUL_LAT, provided the FIFO was empty.
- Stall: with `resp_ready` held at 0, exactly FIFO_DEPTH requests are accepted, then `req_ready` stays 0. One pop re-enables exactly one accept, in the cycle after the pop edge.

## Configuration
- `MUL_ARB_RR_EN` defined: round-robin arbitration. The pointer moves to one past the last granted index, and priority is searched from the pointer upward with wrap-around.
- `MUL_ARB_RR_EN` undefined: fixed priority, lowest index wins. The pointer logic is removed.

## Structure
- Package `mul_arb_pkg`: `OPW` = 64, `PRODW` = 128, and the result entry typedef {id, product}.
- One sub-module, `mul_arb_fifo`: a synchronous FWFT FIFO parameterised by width and depth, with `count` and `full`/`empty` outputs.
- Arbiter, tag pipeline and `occ` counter live in `mul_arbiter`.

## Test plan
- Single request, requester 2, A = B = 64'hFFFFFFFFFFFFFFFF, `resp_ready` = 1 → `resp_valid` in the cycle after edge E+8, `resp_id` = 2, `resp_p` = 128'hFFFFFFFFFFFFFFFE0000000000000001.
- All four requesters valid continuously, `MUL_ARB_RR_EN` defined → grants 0,1,2,3,0,… one per cycle; results return in that ID order with correct products.
- Same stimulus, macro undefined → requester 0 is granted every cycle, and requesters 1–3 get no grant while requester 0 stays valid.
- `resp_ready` = 0, requester 1 streaming → exactly 8 accepts, then `req_ready` = 0 and `busy` = 1. Raising `resp_ready` for one cycle pops one entry and allows exactly one new accept.
- Two accepts with A = 64'h00FFFFFFFABCFFF, B = 64'hABCF, then `rst` pulsed for one cycle three cycles later → no `resp_valid` afterwards, `busy` = 0, `occ` = 0. A post-reset request completes normally.
- Simultaneous FIFO write and pop with the FIFO full → count stays at 8, ordering is preserved, and no entry is lost or duplicated.
